multi_queue_ram: RTL and testbench
==================================

Name: multi_queue_ram

Overview:
- Parametrised successor to the single-channel RAM queue: NUM_QUEUES independent circular FIFOs in one block, each with its own push/pop/flush controls.
- Outputs are first-word-fall-through. Each queue also reports occupancy, almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Sits between the AXI sink front-end and the per-master schedulers: one queue per tracked master/ID.

Parameters:
- DATA_SIZE, 8, width of one stored word.
- QUEUE_LENGTH, 4, entries per queue; any value >= 2, power of two not required.
- NUM_QUEUES, 2, number of independent queues; >= 1.
- ALMOST_FULL_LVL, QUEUE_LENGTH-1, almost_full asserts when count >= this value.
- ALMOST_EMPTY_LVL, 1, almost_empty asserts when count <= this value.
- CW, $clog2(QUEUE_LENGTH+1), derived width of the count fields (localparam, not overridable).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset: state clears immediately while 0.
- valueIn  in  NUM_QUEUES*DATA_SIZE  push data; queue q uses bits [q*DATA_SIZE +: DATA_SIZE].
- valueInValid  in  NUM_QUEUES  per-queue push request.
- consumed  in  NUM_QUEUES  per-queue pop request.
- flush  in  NUM_QUEUES  per-queue synchronous clear.
- valueOut  out  NUM_QUEUES*DATA_SIZE  head word of each queue (FWFT); forced to 0 while that queue is empty.
- count  out  NUM_QUEUES*CW  occupancy of each queue, 0..QUEUE_LENGTH.
- empty  out  NUM_QUEUES  count==0.
- full  out  NUM_QUEUES  count==QUEUE_LENGTH.
- almost_empty  out  NUM_QUEUES  count<=ALMOST_EMPTY_LVL.
- almost_full  out  NUM_QUEUES  count>=ALMOST_FULL_LVL.
- overflow  out  NUM_QUEUES  sticky: a push was dropped.
- underflow  out  NUM_QUEUES  sticky: a pop was ignored.
- clear_err  in  NUM_QUEUES  synchronous clear of both sticky flags for that queue.

Behaviour:
- Reset (reset==0, asynchronous) applies to all queues:
  - head=tail=count=0; storage cleared to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0 (unless ALMOST_FULL_LVL==0).
  - overflow=underflow=0; valueOut=0.
  - Reset asserted mid-operation discards all contents. Deassertion takes effect at the next edge.
- Queues are fully independent: no shared arbitration; all queues may push and pop in the same cycle.
- All flags and count are registered, or derived combinationally from the registered count; they reflect the state after the last edge.
- Push (valueInValid[q]):
  - Accepted iff not full, or pop also accepted this cycle.
  - On accept, the data is written at tail, and tail <= (tail==QUEUE_LENGTH-1) ? 0 : tail+1. Explicit wrap; no modulo on non-power-of-two.
  - A push that is not accepted is dropped: no state change except overflow[q] <= 1.
- Pop (consumed[q]):
  - Accepted iff not empty; then head advances with the same wrap rule.
  - A pop on empty is ignored; underflow[q] <= 1. This holds even if a push is accepted in the same cycle: the new word is stored and count becomes 1.
- Simultaneous accepted push+pop: count unchanged, both pointers advance.
  - On a full queue this is legal: the pop frees the slot the push fills.
  - Count is never incremented past QUEUE_LENGTH or decremented below 0.
- Latency:
  - A word pushed at edge N is visible on valueOut at edge N, i.e. readable in cycle N+1 (one-cycle write-to-read).
  - After a pop at edge N, the next word is presented from edge N.
  - No same-cycle bypass while empty.
- Flush (flush[q]):
  - At the edge, head=tail=count=0; contents become invalid and valueOut reads 0.
  - Flush has priority over a push or pop in the same cycle; both are discarded without setting the error flags.
- Sticky flags:
  - Set on the edge of the offending request; held until clear_err[q] or reset.
  - If clear_err and a new error occur in the same cycle, set wins.
- Widths: counters are CW bits and pointers are $clog2(QUEUE_LENGTH) bits (minimum 1).
- Implementation structure: a generate loop over queues with one queue-control instance per iteration. Target 150-300 lines of RTL.

Test Plan:
- Fill/drain, DATA_SIZE=8, QUEUE_LENGTH=4, queue 0:
  - Push 0x11,0x22,0x33,0x44 -> count 1..4; full=1 after 4th; almost_full=1 at count 3.
  - Pop x4 -> valueOut 0x11,0x22,0x33,0x44 in order, then empty=1, valueOut=0.
- Overflow/underflow:
  - Push 0x55 when full -> dropped, overflow[0]=1, count stays 4.
  - Pop on empty -> underflow=1, count stays 0.
  - clear_err -> both flags 0.
- Simultaneous push+pop when full (QUEUE_LENGTH=4):
  - count stays 4, head word advances, new word appears after the 3 older ones.
  - Simultaneous push+pop when empty -> count=1, underflow=1.
- Wrap with QUEUE_LENGTH=5: push/pop 13 words in a streaming pattern -> output order preserved across 2+ pointer wraps, count never exceeds 5.
- Flush and independence, NUM_QUEUES=2:
  - Queue 1 holds 3 words; flush[1] with push[1] the same cycle -> count[1]=0, error flags unchanged.
  - Queue 0 is pushed in the same cycle and is unaffected.
- Async reset mid-traffic: drop reset to 0 between edges -> count, flags and valueOut clear immediately; first push after release appears normally.

Source files
------------

// File: rtl/multi_queue_ram.sv
// Bank of NUM_QUEUES independent first-word-fall-through circular queues,
// one per tracked master/ID, each with occupancy, threshold and sticky error flags.

module mqr_queue #(
  parameter int DATA_SIZE        = 8,
  parameter int QUEUE_LENGTH     = 4,
  parameter int ALMOST_FULL_LVL  = QUEUE_LENGTH - 1,
  parameter int ALMOST_EMPTY_LVL = 1,
  parameter int CW               = $clog2(QUEUE_LENGTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic                 clear_err,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int             PW       = (QUEUE_LENGTH > 2) ? $clog2(QUEUE_LENGTH) : 1;
  localparam logic [PW-1:0]  LAST     = PW'(QUEUE_LENGTH - 1);
  localparam logic [CW-1:0]  DEPTH    = CW'(QUEUE_LENGTH);
  localparam logic [CW-1:0]  AF_LVL   = CW'(ALMOST_FULL_LVL);
  localparam logic [CW-1:0]  AE_LVL   = CW'(ALMOST_EMPTY_LVL);

  logic [DATA_SIZE-1:0] mem [QUEUE_LENGTH];
  logic [PW-1:0]        head, tail;
  logic [CW-1:0]        count_next;
  logic                 push_ok, pop_ok;

  // Explicit wrap keeps non-power-of-two depths correct without a modulo.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty        = (count == '0);
  assign full         = (count == DEPTH);
  assign almost_empty = (count <= AE_LVL);
  assign almost_full  = (count >= AF_LVL);

  // A pop on a full queue frees the slot that a same-cycle push fills.
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;

  // NOTE: always_comb assigns a default first so no path leaves count_next unassigned (no latch).
  always_comb begin
    count_next = count;
    if (flush)                 count_next = '0;
    else if (push_ok && !pop_ok) count_next = count + CW'(1);
    else if (pop_ok && !push_ok) count_next = count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      // Flush discards requests silently; a new error beats clear_err.
      overflow  <= (overflow  && !clear_err) || (push && !push_ok && !flush);
      underflow <= (underflow && !clear_err) || (pop  && !pop_ok  && !flush);
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push_ok) tail <= next_ptr(tail);
        if (pop_ok)  head <= next_ptr(head);
      end
    end
  end

  // NOTE: storage is reset here only because the block must come up all-zero; it costs a reset net per bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_LENGTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[tail] <= wr_data;
    end
  end

  assign rd_data = empty ? '0 : mem[head];
endmodule

module multi_queue_ram #(
  parameter int DATA_SIZE        = 8,
  parameter int QUEUE_LENGTH     = 4,
  parameter int NUM_QUEUES       = 2,
  parameter int ALMOST_FULL_LVL  = QUEUE_LENGTH - 1,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [NUM_QUEUES*DATA_SIZE-1:0]               valueIn,
  input  logic [NUM_QUEUES-1:0]                         valueInValid,
  input  logic [NUM_QUEUES-1:0]                         consumed,
  input  logic [NUM_QUEUES-1:0]                         flush,
  input  logic [NUM_QUEUES-1:0]                         clear_err,
  output logic [NUM_QUEUES*DATA_SIZE-1:0]               valueOut,
  output logic [NUM_QUEUES*$clog2(QUEUE_LENGTH+1)-1:0]  count,
  output logic [NUM_QUEUES-1:0]                         empty,
  output logic [NUM_QUEUES-1:0]                         full,
  output logic [NUM_QUEUES-1:0]                         almost_empty,
  output logic [NUM_QUEUES-1:0]                         almost_full,
  output logic [NUM_QUEUES-1:0]                         overflow,
  output logic [NUM_QUEUES-1:0]                         underflow
);
  localparam int CW = $clog2(QUEUE_LENGTH + 1);

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
    mqr_queue #(
      .DATA_SIZE        (DATA_SIZE),
      .QUEUE_LENGTH     (QUEUE_LENGTH),
      .ALMOST_FULL_LVL  (ALMOST_FULL_LVL),
      .ALMOST_EMPTY_LVL (ALMOST_EMPTY_LVL),
      .CW               (CW)
    ) u_queue (
      .clock        (clock),
      .reset        (reset),
      .wr_data      (valueIn[q*DATA_SIZE +: DATA_SIZE]),
      .push         (valueInValid[q]),
      .pop          (consumed[q]),
      .flush        (flush[q]),
      .clear_err    (clear_err[q]),
      .rd_data      (valueOut[q*DATA_SIZE +: DATA_SIZE]),
      .count        (count[q*CW +: CW]),
      .empty        (empty[q]),
      .full         (full[q]),
      .almost_empty (almost_empty[q]),
      .almost_full  (almost_full[q]),
      .overflow     (overflow[q]),
      .underflow    (underflow[q])
    );
  end
endmodule

// File: tb/tb_multi_queue_ram.sv
// Self-checking bench for multi_queue_ram: vector table on a 2x4 instance,
// scoreboarded streaming on a 1x5 instance, flush/independence and async reset sequences.

module tb_multi_queue_ram;
  localparam int DS   = 8;
  localparam int QL_A = 4;
  localparam int QL_B = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Instance A: 2 queues x 4 entries
  logic [15:0] a_value_in, a_value_out;
  logic [1:0]  a_valid, a_consumed, a_flush, a_clear_err;
  logic [5:0]  a_count;
  logic [1:0]  a_empty, a_full, a_almost_empty, a_almost_full, a_overflow, a_underflow;

  // Instance B: 1 queue x 5 entries
  logic [7:0]  b_value_in, b_value_out;
  logic [0:0]  b_valid, b_consumed, b_flush, b_clear_err;
  logic [2:0]  b_count;
  logic [0:0]  b_empty, b_full, b_almost_empty, b_almost_full, b_overflow, b_underflow;

  multi_queue_ram #(.DATA_SIZE(DS), .QUEUE_LENGTH(QL_A), .NUM_QUEUES(2)) dut_a (
    .clock(clock), .reset(reset), .valueIn(a_value_in), .valueInValid(a_valid),
    .consumed(a_consumed), .flush(a_flush), .clear_err(a_clear_err),
    .valueOut(a_value_out), .count(a_count), .empty(a_empty), .full(a_full),
    .almost_empty(a_almost_empty), .almost_full(a_almost_full),
    .overflow(a_overflow), .underflow(a_underflow)
  );

  multi_queue_ram #(.DATA_SIZE(DS), .QUEUE_LENGTH(QL_B), .NUM_QUEUES(1)) dut_b (
    .clock(clock), .reset(reset), .valueIn(b_value_in), .valueInValid(b_valid),
    .consumed(b_consumed), .flush(b_flush), .clear_err(b_clear_err),
    .valueOut(b_value_out), .count(b_count), .empty(b_empty), .full(b_full),
    .almost_empty(b_almost_empty), .almost_full(b_almost_full),
    .overflow(b_overflow), .underflow(b_underflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Flags packed as {full, almost_full, empty, almost_empty, overflow, underflow}
  typedef struct {
    string      name;
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] din;
    logic [2:0] exp_count;
    logic [7:0] exp_out;
    logic [5:0] exp_flags;
  } vec_t;

  function automatic vec_t v(input string n, input logic push, input logic pop, input logic clr,
                             input logic [7:0] din, input logic [2:0] c, input logic [7:0] o,
                             input logic [5:0] f);
    vec_t r;
    r.name = n; r.push = push; r.pop = pop; r.clr = clr; r.din = din;
    r.exp_count = c; r.exp_out = o; r.exp_flags = f;
    return r;
  endfunction

  function automatic logic [5:0] a_flags(input int q);
    return {a_full[q], a_almost_full[q], a_empty[q], a_almost_empty[q], a_overflow[q], a_underflow[q]};
  endfunction

  task automatic idle_inputs();
    a_value_in = '0; a_valid = '0; a_consumed = '0; a_flush = '0; a_clear_err = '0;
    b_value_in = '0; b_valid = '0; b_consumed = '0; b_flush = '0; b_clear_err = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         mc, pushed, popped, max_cnt, cyc;
    logic       do_push, do_pop;
    logic [7:0] d;

    idle_inputs();
    #12;
    // Reset state, observed while reset is still held low
    check("rst_count_a", a_count, 6'd0);
    check("rst_out_a", a_value_out, 16'h0);
    check("rst_flags_a0", a_flags(0), 6'b001100);
    check("rst_flags_a1", a_flags(1), 6'b001100);
    check("rst_count_b", b_count, 3'd0);
    @(posedge clock); #3;
    reset = 1'b1;
    #3;

    // Queue 0 of instance A: fill/drain, overflow/underflow, push+pop at full and at empty
    vecs.push_back(v("push11",      1, 0, 0, 8'h11, 3'd1, 8'h11, 6'b000100));
    vecs.push_back(v("push22",      1, 0, 0, 8'h22, 3'd2, 8'h11, 6'b000000));
    vecs.push_back(v("push33",      1, 0, 0, 8'h33, 3'd3, 8'h11, 6'b010000));
    vecs.push_back(v("push44",      1, 0, 0, 8'h44, 3'd4, 8'h11, 6'b110000));
    vecs.push_back(v("push55_full", 1, 0, 0, 8'h55, 3'd4, 8'h11, 6'b110010));
    vecs.push_back(v("clr_ovf",     0, 0, 1, 8'h00, 3'd4, 8'h11, 6'b110000));
    vecs.push_back(v("pop1",        0, 1, 0, 8'h00, 3'd3, 8'h22, 6'b010000));
    vecs.push_back(v("pop2",        0, 1, 0, 8'h00, 3'd2, 8'h33, 6'b000000));
    vecs.push_back(v("pop3",        0, 1, 0, 8'h00, 3'd1, 8'h44, 6'b000100));
    vecs.push_back(v("pop4",        0, 1, 0, 8'h00, 3'd0, 8'h00, 6'b001100));
    vecs.push_back(v("pop_empty",   0, 1, 0, 8'h00, 3'd0, 8'h00, 6'b001101));
    vecs.push_back(v("clr_unf",     0, 0, 1, 8'h00, 3'd0, 8'h00, 6'b001100));
    vecs.push_back(v("refill11",    1, 0, 0, 8'h11, 3'd1, 8'h11, 6'b000100));
    vecs.push_back(v("refill22",    1, 0, 0, 8'h22, 3'd2, 8'h11, 6'b000000));
    vecs.push_back(v("refill33",    1, 0, 0, 8'h33, 3'd3, 8'h11, 6'b010000));
    vecs.push_back(v("refill44",    1, 0, 0, 8'h44, 3'd4, 8'h11, 6'b110000));
    vecs.push_back(v("pushpop_full",1, 1, 0, 8'h66, 3'd4, 8'h22, 6'b110000));
    vecs.push_back(v("drain33",     0, 1, 0, 8'h00, 3'd3, 8'h33, 6'b010000));
    vecs.push_back(v("drain44",     0, 1, 0, 8'h00, 3'd2, 8'h44, 6'b000000));
    vecs.push_back(v("drain66",     0, 1, 0, 8'h00, 3'd1, 8'h66, 6'b000100));
    vecs.push_back(v("drain_last",  0, 1, 0, 8'h00, 3'd0, 8'h00, 6'b001100));
    vecs.push_back(v("pushpop_empty",1,1, 0, 8'h77, 3'd1, 8'h77, 6'b000101));
    vecs.push_back(v("pop77",       0, 1, 0, 8'h00, 3'd0, 8'h00, 6'b001101));
    vecs.push_back(v("clr_final",   0, 0, 1, 8'h00, 3'd0, 8'h00, 6'b001100));

    for (int i = 0; i < vecs.size(); i++) begin
      idle_inputs();
      a_valid[0] = vecs[i].push;
      a_consumed[0] = vecs[i].pop;
      a_clear_err[0] = vecs[i].clr;
      a_value_in[7:0] = vecs[i].din;
      tick();
      check({vecs[i].name, "_count"}, a_count[2:0], vecs[i].exp_count);
      check({vecs[i].name, "_out"}, a_value_out[7:0], vecs[i].exp_out);
      check({vecs[i].name, "_flags"}, a_flags(0), vecs[i].exp_flags);
    end
    idle_inputs();
    check("q1_untouched", {a_count[5:3], a_value_out[15:8], a_flags(1)}, {3'd0, 8'h00, 6'b001100});

    // Streaming through a 5-deep queue: order kept across pointer wraps
    mc = 0; pushed = 0; popped = 0; max_cnt = 0; cyc = 0;
    while (!(pushed == 13 && mc == 0) && cyc < 200) begin
      do_pop  = (mc > 0) && (cyc >= 6) && ((cyc % 3 == 0) || pushed == 13);
      do_push = (pushed < 13) && (cyc % 4 != 3) && (mc < QL_B || do_pop);
      idle_inputs();
      if (do_pop) begin
        check("b_head", b_value_out, sb[0]);
        void'(sb.pop_front());
        popped++;
      end
      if (do_push) begin
        d = 8'hA0 ^ 8'(pushed * 7);
        sb.push_back(d);
        b_value_in = d;
        pushed++;
      end
      b_valid[0] = do_push;
      b_consumed[0] = do_pop;
      tick();
      mc = mc + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      if (int'(b_count) > max_cnt) max_cnt = int'(b_count);
      if (b_count !== 3'(mc)) check("b_count", b_count, 3'(mc));
      cyc++;
    end
    idle_inputs();
    check("b_finished_in_budget", (cyc < 200) ? 32'd1 : 32'd0, 32'd1);
    check("b_popped", popped, 13);
    check("b_reached_full", max_cnt, QL_B);
    check("b_no_errors", {b_overflow, b_underflow, b_empty}, 3'b001);

    // Flush on queue 1 with a same-cycle push; queue 0 pushes alongside
    a_consumed[1] = 1'b1;
    tick();
    idle_inputs();
    check("q1_unf_set", a_underflow[1], 1'b1);
    for (int i = 0; i < 3; i++) begin
      a_valid[1] = 1'b1;
      a_value_in[15:8] = 8'hA1 + 8'(i);
      tick();
    end
    idle_inputs();
    check("q1_pre_flush", {a_count[5:3], a_value_out[15:8]}, {3'd3, 8'hA1});
    a_flush[1] = 1'b1; a_valid[1] = 1'b1; a_value_in[15:8] = 8'hEE;
    a_valid[0] = 1'b1; a_value_in[7:0] = 8'h99;
    tick();
    idle_inputs();
    check("q1_flush_count", a_count[5:3], 3'd0);
    check("q1_flush_out", a_value_out[15:8], 8'h00);
    check("q1_flush_flags", a_flags(1), 6'b001101);
    check("q0_independent", {a_count[2:0], a_value_out[7:0]}, {3'd1, 8'h99});
    a_valid[1] = 1'b1; a_value_in[15:8] = 8'hC3; a_clear_err[1] = 1'b1;
    tick();
    idle_inputs();
    check("q1_after_flush", {a_count[5:3], a_value_out[15:8], a_flags(1)}, {3'd1, 8'hC3, 6'b000100});

    // Async reset mid-traffic
    a_valid[0] = 1'b1; a_value_in[7:0] = 8'hA0; a_consumed[1] = 1'b1;
    tick();
    idle_inputs();
    check("pre_reset", {a_count, a_underflow}, {3'd0, 3'd2, 2'b00});
    #2 reset = 1'b0;
    #1;
    check("async_count", a_count, 6'd0);
    check("async_out", a_value_out, 16'h0);
    check("async_flags", {a_flags(1), a_flags(0)}, {6'b001100, 6'b001100});
    a_valid[0] = 1'b1; a_value_in[7:0] = 8'h5A;
    tick();
    idle_inputs();
    check("held_in_reset", {a_count[2:0], a_value_out[7:0]}, {3'd0, 8'h00});
    #2 reset = 1'b1;
    #1;
    a_valid[0] = 1'b1; a_value_in[7:0] = 8'hB1;
    tick();
    idle_inputs();
    check("post_reset_push", {a_count[2:0], a_value_out[7:0], a_flags(0)}, {3'd1, 8'hB1, 6'b000100});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
